// File: rtl/command_issuer_if.sv
// Producer/controller-side bundle of the command_issuer.
// Ports: in_valid/in_command/in_ready (producer handshake), flush,
//        command/syscall (controller side), count/busy (status).
interface command_issuer_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [11:0]   in_command;
    logic          in_ready;
    logic          flush;
    logic [11:0]   command;
    logic          syscall;
    logic [CW-1:0] count;
    logic          busy;

    // Block's own view.
    modport slave (
        input  in_valid, in_command, flush,
        output in_ready, command, syscall, count, busy
    );

    // Producer/driver view.
    modport master (
        output in_valid, in_command, flush,
        input  in_ready, command, syscall, count, busy
    );
endinterface

// File: rtl/command_issuer.sv
// Purpose: queue 12-bit instruction words and issue them one at a time to the
//          controller as command + one-cycle syscall pulse, spaced ISSUE_GAP cycles.
// Latency: push at edge E into an idle, empty block -> syscall high in the cycle after E+1.
// Backpressure: in_ready low while full or in reset; no bypass, so a pop does not
//          free a slot for a push on the same edge.
// Ports: clk, rst (sync active-high), bus (command_issuer_if.slave).
module command_issuer #(
    parameter int DEPTH     = 8,
    parameter int ISSUE_GAP = 4
) (
    input  logic            clk,
    input  logic            rst,
    command_issuer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(ISSUE_GAP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [11:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [GW-1:0] gap;
    logic [11:0]   command_q;
    logic          syscall_q;

    logic          push;
    logic          pop;
    logic          gap_load;
    logic          gap_dec;
    logic          can_issue;

    assign bus.in_ready = !rst && (count < CW'(DEPTH));
    // flush wins over a simultaneous push or pop
    assign push         = bus.in_valid && bus.in_ready && !bus.flush;
    assign can_issue    = (count != '0) && !bus.flush;

    assign bus.command  = command_q;
    assign bus.syscall  = syscall_q;
    assign bus.count    = count;
    assign bus.busy     = (state != S_IDLE) || (count != '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (can_issue) next_state = S_ISSUE;
            S_ISSUE: next_state = S_WAIT;
            S_WAIT:  if (gap == '0) next_state = can_issue ? S_ISSUE : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output / control logic
    always_comb begin
        pop      = 1'b0;
        gap_load = 1'b0;
        gap_dec  = 1'b0;
        case (state)
            S_IDLE:  pop = can_issue;
            S_ISSUE: gap_load = 1'b1;
            S_WAIT: begin
                if (gap == '0) pop = can_issue;
                else           gap_dec = 1'b1;
            end
            default: ;
        endcase
    end

    // Queue, gap counter and registered controller outputs.
    // S_WAIT lasts gap+1 cycles, so loading ISSUE_GAP-2 gives ISSUE_GAP-1 wait cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            gap       <= '0;
            command_q <= 12'h000;
            syscall_q <= 1'b0;
        end else begin
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: ;
                endcase
            end
            if (pop) command_q <= mem[rd_ptr];
            // syscall is high during S_ISSUE, which always follows a pop
            syscall_q <= pop;
            if (gap_load)     gap <= GW'(ISSUE_GAP - 2);
            else if (gap_dec) gap <= gap - GW'(1);
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_command;
    end
endmodule

// File: tb/tb_command_issuer.sv
module tb_command_issuer;
    localparam int DEPTH = 8;
    localparam int GAP   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    command_issuer_if #(.DEPTH(DEPTH)) bus ();

    command_issuer #(.DEPTH(DEPTH), .ISSUE_GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of pending words plus the edge index of the last issue.
    // Issue rule: pop at an edge when the queue is non-empty, no flush, and at
    // least GAP edges have passed since the previous pop.
    logic [11:0] q [$];
    int          cyc       = 0;
    int          last_pop  = 0;
    bit          have_pop  = 1'b0;
    logic [11:0] m_cmd     = 12'h000;
    int          sys_cycles [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        bit do_push;
        bit do_pop;
        bit m_sys;
        bit m_busy;
        bit m_ready;
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            have_pop = 1'b0;
            m_cmd    = 12'h000;
        end else begin
            do_push = bus.in_valid && (q.size() < DEPTH) && !bus.flush;
            do_pop  = !bus.flush && (q.size() != 0) && (!have_pop || (cyc - last_pop >= GAP));
            if (do_pop) begin
                m_cmd    = q.pop_front();
                last_pop = cyc;
                have_pop = 1'b1;
            end
            if (do_push) q.push_back(bus.in_command);
            if (bus.flush) q.delete();
        end
        #1;
        m_ready = !rst && (q.size() < DEPTH);
        m_sys   = have_pop && (cyc == last_pop);
        m_busy  = (q.size() != 0) || (have_pop && (cyc - last_pop <= GAP - 1));
        check("in_ready", 32'(bus.in_ready), 32'(m_ready));
        check("syscall",  32'(bus.syscall),  32'(m_sys));
        check("command",  32'(bus.command),  32'(m_cmd));
        check("count",    32'(bus.count),    32'(q.size()));
        check("busy",     32'(bus.busy),     32'(m_busy));
        if (bus.syscall) sys_cycles.push_back(cyc);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_word(input logic [11:0] w);
        bus.in_valid   = 1'b1;
        bus.in_command = w;
        step();
        bus.in_valid   = 1'b0;
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_command = 12'h000;
        bus.flush      = 1'b0;

        // Reset state
        rst = 1'b1;
        step();
        step();
        check("rst_count",    32'(bus.count),    32'd0);
        check("rst_command",  32'(bus.command),  32'h000);
        check("rst_syscall",  32'(bus.syscall),  32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        step();

        // Single command: syscall in the cycle after push edge + 1
        push_word(12'h0D1);
        check("single_sys_early", 32'(bus.syscall), 32'd0);
        step();
        check("single_sys", 32'(bus.syscall), 32'd1);
        check("single_cmd", 32'(bus.command), 32'h0D1);
        step();
        check("single_sys_one", 32'(bus.syscall), 32'd0);
        idle(4);
        check("single_busy_done", 32'(bus.busy),  32'd0);
        check("single_count",     32'(bus.count), 32'd0);

        // Burst of three, including a CAS opcode
        sys_cycles.delete();
        push_word(12'h041);
        push_word(12'h283);
        push_word(12'hE53);
        idle(16);
        check("burst_npulses", 32'(sys_cycles.size()), 32'd3);
        if (sys_cycles.size() == 3) begin
            check("burst_gap1", 32'(sys_cycles[1] - sys_cycles[0]), 32'(GAP));
            check("burst_gap2", 32'(sys_cycles[2] - sys_cycles[1]), 32'(GAP));
        end
        check("burst_last_cmd", 32'(bus.command), 32'hE53);

        // Fill to full, then drain; repeat so pointers wrap
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 12; i++) push_word(12'($urandom));
            check("full_count",    32'(bus.count),    32'(DEPTH));
            check("full_in_ready", 32'(bus.in_ready), 32'd0);
            idle(40);
            check("drained_count", 32'(bus.count), 32'd0);
        end

        // Flush during S_WAIT with count=5 and a push offered
        for (int i = 0; i < 7; i++) push_word(12'($urandom));
        check("pre_flush_count", 32'(bus.count), 32'd5);
        bus.in_valid   = 1'b1;
        bus.in_command = 12'hABC;
        bus.flush      = 1'b1;
        step();
        check("flush_count", 32'(bus.count), 32'd0);
        sys_cycles.delete();
        idle(10);
        check("flush_no_sys", 32'(sys_cycles.size()), 32'd0);
        check("flush_idle",   32'(bus.busy),          32'd0);

        // Reset mid-S_WAIT
        for (int i = 0; i < 7; i++) push_word(12'($urandom));
        step();
        rst = 1'b1;
        step();
        check("midrst_sys",   32'(bus.syscall), 32'd0);
        check("midrst_cmd",   32'(bus.command), 32'h000);
        check("midrst_count", 32'(bus.count),   32'd0);
        rst = 1'b0;
        step();
        check("midrst_ready", 32'(bus.in_ready), 32'd1);
        push_word(12'h5A5);
        step();
        check("midrst_fresh_sys", 32'(bus.syscall), 32'd1);
        check("midrst_fresh_cmd", 32'(bus.command), 32'h5A5);
        idle(6);

        // Randomized traffic with varying load, occasional flush and reset
        for (int i = 0; i < 4000; i++) begin
            int load;
            load = (i / 500) % 4;
            bus.in_valid   = ($urandom_range(0, 3) < load);
            bus.in_command = 12'($urandom);
            bus.flush      = ($urandom_range(0, 59) == 0);
            rst            = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        idle(40);
        check("final_idle", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
